// File: rtl/reduce_accum_unit.sv
// ---------------------------------------------------------------------------
// reduce_accum_unit
//   Reduces N_IN channels of WIDTH bits bitwise with a selectable operation
//   (OR / AND / XOR / NOR) and accumulates the per-beat results across a
//   multi-beat transaction. Valid/ready handshake on both sides, one
//   registered output slot.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready (combinational)
//   in_data    channel k = in_data[k*WIDTH +: WIDTH]
//   in_op      00 OR, 01 AND, 10 XOR, 11 NOR; sampled on the first beat only
//   in_last    final beat of the transaction
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out_data   accumulated reduction (inverted for NOR)
//   out_beats  beats in the transaction, saturating at 2**CNT_W-1
//   out_sat    beat count was clipped during the transaction
// ---------------------------------------------------------------------------
module reduce_accum_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_IN  = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [1:0]              in_op,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_sat
);

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;

    logic               accept;
    logic               first;
    logic [1:0]         op_cur;
    logic [WIDTH-1:0]   beat_red;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               sat_next;
    logic [WIDTH-1:0]   res_data;

    // Slot accepts a new beat when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = (state == IDLE);

    // The op of an open transaction is the latched one; the first beat uses in_op.
    assign op_cur   = first ? in_op : op_q;

    // Per-beat reduction across channels; NOR reduces as OR.
    always_comb begin : beat_reduce
        beat_red = in_data[WIDTH-1:0];
        for (int unsigned k = 1; k < N_IN; k++) begin
            case (op_cur)
                OP_AND:  beat_red = beat_red & in_data[k*WIDTH +: WIDTH];
                OP_XOR:  beat_red = beat_red ^ in_data[k*WIDTH +: WIDTH];
                default: beat_red = beat_red | in_data[k*WIDTH +: WIDTH];
            endcase
        end
    end

    // Fold the beat into the running accumulator and advance the beat count.
    always_comb begin : accum_next
        acc_next = beat_red;
        cnt_next = CNT_ONE;
        sat_next = 1'b0;
        if (!first) begin
            case (op_q)
                OP_AND:  acc_next = acc_q & beat_red;
                OP_XOR:  acc_next = acc_q ^ beat_red;
                default: acc_next = acc_q | beat_red;
            endcase
            if (cnt_q == CNT_MAX) begin
                cnt_next = cnt_q;
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_ONE;
                sat_next = sat_q;
            end
        end
    end

    // NOR inversion is applied only when the result leaves the unit.
    assign res_data = (op_cur == OP_NOR) ? ~acc_next : acc_next;

    // Transaction FSM, accumulator state and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_OR;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= acc_next;
                cnt_q <= cnt_next;
                sat_q <= sat_next;
                if (first) begin
                    op_q <= in_op;
                end
                case (state)
                    IDLE:    state <= in_last ? IDLE : ACCUM;
                    ACCUM:   state <= in_last ? IDLE : ACCUM;
                    default: state <= IDLE;
                endcase
            end

            // A last beat reloads the slot even while it is being drained.
            if (accept && in_last) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_beats <= cnt_next;
                out_sat   <= sat_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reduce_accum_unit.sv
// ---------------------------------------------------------------------------
// tb_reduce_accum_unit
//   Drives two instances (CNT_W=4 and CNT_W=2) with identical stimulus and
//   compares them against a transaction-level reference model: each accepted
//   beat is queued, and on the last beat the whole transaction is reduced with
//   plain loops to produce the expected result slot.
// ---------------------------------------------------------------------------
module tb_reduce_accum_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned DW    = N_IN * WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_op;
    logic            in_last;
    logic            out_ready;

    logic            in_ready_a, in_ready_b;
    logic            out_valid_a, out_valid_b;
    logic [7:0]      out_data_a, out_data_b;
    logic [3:0]      out_beats_a;
    logic [1:0]      out_beats_b;
    logic            out_sat_a, out_sat_b;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [DW-1:0]   txn_q[$];
    logic [1:0]      txn_op;
    logic            m_valid;
    logic [7:0]      m_data;
    int              m_len;

    always #5 clk = ~clk;

    reduce_accum_unit #(.WIDTH(8), .N_IN(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_beats(out_beats_a), .out_sat(out_sat_a)
    );

    reduce_accum_unit #(.WIDTH(8), .N_IN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_beats(out_beats_b), .out_sat(out_sat_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] pk(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Apply OR/AND/XOR to two values; NOR behaves as OR here.
    function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        if (op == 2'b01) return a & b;
        if (op == 2'b10) return a ^ b;
        return a | b;
    endfunction

    // Whole-transaction result from the queued beats.
    function automatic logic [7:0] txn_result();
        logic [7:0] res;
        logic [7:0] beat;
        logic [DW-1:0] d;
        for (int i = 0; i < txn_q.size(); i++) begin
            d = txn_q[i];
            beat = d[7:0];
            for (int k = 1; k < 3; k++) beat = apply_op(txn_op, beat, d[k*8 +: 8]);
            res = (i == 0) ? beat : apply_op(txn_op, res, beat);
        end
        return (txn_op == 2'b11) ? ~res : res;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid_a"}, 32'(out_valid_a), 32'(m_valid));
        check({tag, "_valid_b"}, 32'(out_valid_b), 32'(m_valid));
        if (m_valid) begin
            check({tag, "_data_a"},  32'(out_data_a),  32'(m_data));
            check({tag, "_data_b"},  32'(out_data_b),  32'(m_data));
            check({tag, "_beats_a"}, 32'(out_beats_a), 32'((m_len > 15) ? 15 : m_len));
            check({tag, "_sat_a"},   32'(out_sat_a),   32'(m_len > 15));
            check({tag, "_beats_b"}, 32'(out_beats_b), 32'((m_len > 3) ? 3 : m_len));
            check({tag, "_sat_b"},   32'(out_sat_b),   32'(m_len > 3));
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_data = '0; in_op = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        txn_q.delete();
        m_valid = 1'b0;
        check({tag, "_rst_valid"}, 32'(out_valid_a), 32'(0));
        check({tag, "_rst_data"},  32'(out_data_a),  32'(0));
        check({tag, "_rst_beats"}, 32'(out_beats_a), 32'(0));
        check({tag, "_rst_sat"},   32'(out_sat_a),   32'(0));
        check({tag, "_rst_valid_b"}, 32'(out_valid_b), 32'(0));
    endtask

    // One clock of stimulus with model update and output checks.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic [1:0] op, input logic last, input logic ordy);
        logic acc;
        in_valid = v; in_data = d; in_op = op; in_last = last; out_ready = ordy;
        #1;
        check({tag, "_in_ready_a"}, 32'(in_ready_a), 32'(!m_valid || ordy));
        check({tag, "_in_ready_b"}, 32'(in_ready_b), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        @(posedge clk); #1;
        if (acc) begin
            if (txn_q.size() == 0) txn_op = op;
            txn_q.push_back(d);
        end
        if (acc && last) begin
            m_valid = 1'b1;
            m_data  = txn_result();
            m_len   = txn_q.size();
            txn_q.delete();
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        do_reset("init");

        // Single-beat OR
        step("t1", 1, pk(8'h01, 8'h02, 8'h10), 2'b00, 1, 1);
        check("t1_const_data", 32'(out_data_a), 32'h13);
        check("t1_const_beats", 32'(out_beats_a), 32'd1);
        check("t1_const_sat", 32'(out_sat_a), 32'd0);

        // 3-beat AND, op changes mid-transaction are ignored
        step("t2a", 1, pk(8'hFF, 8'hF0, 8'h3C), 2'b01, 0, 1);
        step("t2b", 1, pk(8'hFF, 8'hFF, 8'hF8), 2'b10, 0, 1);
        step("t2c", 1, pk(8'h7F, 8'hFF, 8'hFF), 2'b00, 1, 1);
        check("t2_const_data", 32'(out_data_a), 32'h30);
        check("t2_const_beats", 32'(out_beats_a), 32'd3);

        // NOR and XOR two-beat transactions
        step("t3a", 1, pk(8'h00, 8'h01, 8'h00), 2'b11, 0, 1);
        step("t3b", 1, pk(8'h02, 8'h00, 8'h00), 2'b11, 1, 1);
        check("t3_nor_data", 32'(out_data_a), 32'hFC);
        step("t3c", 1, pk(8'h0F, 8'hF0, 8'h00), 2'b10, 0, 1);
        step("t3d", 1, pk(8'hFF, 8'h00, 8'h00), 2'b10, 1, 1);
        check("t3_xor_data", 32'(out_data_a), 32'h00);
        check("t3_xor_valid", 32'(out_valid_a), 32'd1);

        // Backpressure: result held, beats stalled, then drain + accept together
        step("t4a", 1, pk(8'h01, 8'h02, 8'h10), 2'b00, 1, 1);
        step("t4b", 1, pk(8'h05, 8'h00, 8'h00), 2'b00, 1, 0);
        check("t4_stall_ready", 32'(in_ready_a), 32'd0);
        check("t4_hold_data", 32'(out_data_a), 32'h13);
        step("t4c", 1, pk(8'h05, 8'h00, 8'h00), 2'b00, 1, 0);
        check("t4_hold_data2", 32'(out_data_a), 32'h13);
        step("t4d", 1, pk(8'h05, 8'h00, 8'h00), 2'b00, 1, 1);
        check("t4_reload_data", 32'(out_data_a), 32'h05);
        check("t4_reload_valid", 32'(out_valid_a), 32'd1);
        step("t4e", 0, '0, 2'b00, 0, 1);
        check("t4_drained", 32'(out_valid_a), 32'd0);

        // Saturation on the CNT_W=2 instance, then clears on the next txn
        for (int i = 0; i < 5; i++)
            step("t5", 1, pk(8'(1 << i), 8'h00, 8'h00), 2'b00, (i == 4), 1);
        check("t5_beats_b", 32'(out_beats_b), 32'd3);
        check("t5_sat_b", 32'(out_sat_b), 32'd1);
        check("t5_beats_a", 32'(out_beats_a), 32'd5);
        check("t5_data", 32'(out_data_b), 32'h1F);
        step("t5s", 1, pk(8'h40, 8'h00, 8'h00), 2'b00, 1, 1);
        check("t5_sat_clear", 32'(out_sat_b), 32'd0);
        check("t5_beats_one", 32'(out_beats_b), 32'd1);

        // Reset in the middle of a transaction
        step("t6a", 1, pk(8'hA0, 8'h00, 8'h00), 2'b00, 0, 1);
        step("t6b", 1, pk(8'h0A, 8'h00, 8'h00), 2'b00, 0, 1);
        do_reset("t6");
        step("t6c", 1, pk(8'h05, 8'h00, 8'h00), 2'b00, 1, 1);
        check("t6_data", 32'(out_data_a), 32'h05);
        check("t6_beats", 32'(out_beats_a), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd");
            end else begin
                step("rnd",
                     ($urandom_range(0, 9) < 7),
                     DW'($urandom),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 9) < 7));
            end
        end

        step("end", 0, '0, 2'b00, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
